// File: rtl/gbe_cfg_master.sv
`default_nettype none
// ============================================================================
// Module   : gbe_cfg_master
// Brief    : Wishbone initiator that writes latched MAC/IP/gateway/port/enable
//            values into the GbE UDP core register block, with optional readback.
// Revision : 1.0 - initial release
// ============================================================================
module gbe_cfg_master #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter bit          VERIFY    = 1'b1,
    parameter logic [15:0] TIMEOUT   = 16'd255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start,
    input  logic [47:0] cfg_mac,
    input  logic [31:0] cfg_ip,
    input  logic [7:0]  cfg_gateway,
    input  logic [15:0] cfg_port,
    input  logic        cfg_enable,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [2:0]  err_code,
    output logic [2:0]  err_index
);

    localparam logic [2:0]  S_IDLE     = 3'd0;
    localparam logic [2:0]  S_REQ      = 3'd1;
    localparam logic [2:0]  S_GAP      = 3'd2;
    localparam logic [2:0]  S_FAIL     = 3'd3;
    localparam logic [2:0]  S_DONE     = 3'd4;

    localparam logic [2:0]  ERR_NONE   = 3'd0;
    localparam logic [2:0]  ERR_WB     = 3'd1;
    localparam logic [2:0]  ERR_TMO    = 3'd2;
    localparam logic [2:0]  ERR_CMP    = 3'd3;

    localparam logic [2:0]  C_LAST_IDX = 3'd4;
    localparam logic [15:0] C_TMO_LAST = TIMEOUT - 16'd1;

    function automatic logic [7:0] f_off(input logic [2:0] idx);
        case (idx)
            3'd0:    f_off = 8'h00;
            3'd1:    f_off = 8'h04;
            3'd2:    f_off = 8'h0C;
            3'd3:    f_off = 8'h10;
            3'd4:    f_off = 8'h20;
            default: f_off = 8'h00;
        endcase
    endfunction

    function automatic logic [3:0] f_sel(input logic [2:0] idx);
        case (idx)
            3'd0:    f_sel = 4'b0011;
            3'd1:    f_sel = 4'b1111;
            3'd2:    f_sel = 4'b0001;
            3'd3:    f_sel = 4'b1111;
            3'd4:    f_sel = 4'b0111;
            default: f_sel = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] f_mask(input logic [2:0] idx);
        case (idx)
            3'd0:    f_mask = 32'h0000_FFFF;
            3'd1:    f_mask = 32'hFFFF_FFFF;
            3'd2:    f_mask = 32'h0000_00FF;
            3'd3:    f_mask = 32'hFFFF_FFFF;
            3'd4:    f_mask = 32'h0001_FFFF;
            default: f_mask = 32'h0000_0000;
        endcase
    endfunction

    function automatic logic [31:0] f_data(input logic [2:0]  idx,
                                           input logic [47:0] mac,
                                           input logic [31:0] ip,
                                           input logic [7:0]  gw,
                                           input logic [15:0] port,
                                           input logic        en);
        case (idx)
            3'd0:    f_data = {16'h0000, mac[47:32]};
            3'd1:    f_data = mac[31:0];
            3'd2:    f_data = {24'h00_0000, gw};
            3'd3:    f_data = ip;
            3'd4:    f_data = {15'h0000, en, port};
            default: f_data = 32'h0000_0000;
        endcase
    endfunction

    logic [2:0]  state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic        rd_q, rd_d;
    logic [15:0] tmo_q, tmo_d;
    logic [47:0] mac_q, mac_d;
    logic [31:0] ip_q, ip_d;
    logic [7:0]  gw_q, gw_d;
    logic [15:0] port_q, port_d;
    logic        en_q, en_d;

    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [2:0]  code_q, code_d;
    logic [2:0]  eidx_q, eidx_d;

    logic [2:0]  fail_code;
    logic        w_last;
    logic        w_cmp_bad;
    logic [31:0] w_cur_mask;

    assign w_last     = (idx_q == C_LAST_IDX) && (rd_q || !VERIFY);
    assign w_cur_mask = f_mask(idx_q);
    assign w_cmp_bad  = ((wb_dat_i ^ f_data(idx_q, mac_q, ip_q, gw_q, port_q, en_q))
                         & w_cur_mask) != 32'h0000_0000;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            idx_q   <= 3'd0;
            rd_q    <= 1'b0;
            tmo_q   <= 16'd0;
            mac_q   <= 48'd0;
            ip_q    <= 32'd0;
            gw_q    <= 8'd0;
            port_q  <= 16'd0;
            en_q    <= 1'b0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= 32'd0;
            dat_q   <= 32'd0;
            sel_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            code_q  <= ERR_NONE;
            eidx_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rd_q    <= rd_d;
            tmo_q   <= tmo_d;
            mac_q   <= mac_d;
            ip_q    <= ip_d;
            gw_q    <= gw_d;
            port_q  <= port_d;
            en_q    <= en_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
            code_q  <= code_d;
            eidx_q  <= eidx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        rd_d      = rd_q;
        tmo_d     = tmo_q;
        mac_d     = mac_q;
        ip_d      = ip_q;
        gw_d      = gw_q;
        port_d    = port_q;
        en_d      = en_q;
        fail_code = ERR_NONE;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_REQ;
                    idx_d   = 3'd0;
                    rd_d    = 1'b0;
                    tmo_d   = 16'd0;
                    mac_d   = cfg_mac;
                    ip_d    = cfg_ip;
                    gw_d    = cfg_gateway;
                    port_d  = cfg_port;
                    en_d    = cfg_enable;
                end
            end
            S_REQ: begin
                // err beats ack, and any response beats timeout expiry
                if (wb_err_i) begin
                    state_d   = S_FAIL;
                    fail_code = ERR_WB;
                end else if (wb_ack_i) begin
                    if (rd_q && w_cmp_bad) begin
                        state_d   = S_FAIL;
                        fail_code = ERR_CMP;
                    end else if (w_last) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_GAP;
                    end
                end else if (tmo_q == C_TMO_LAST) begin
                    state_d   = S_FAIL;
                    fail_code = ERR_TMO;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            S_GAP: begin
                state_d = S_REQ;
                tmo_d   = 16'd0;
                if (idx_q == C_LAST_IDX) begin
                    idx_d = 3'd0;
                    rd_d  = 1'b1;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            S_FAIL:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Bus outputs are registered from the next state so they line up with it.
    always_comb begin
        cyc_d   = (state_d == S_REQ);
        we_d    = cyc_d && !rd_d;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        if (cyc_d) begin
            adr_d = BASE_ADDR + {24'h00_0000, f_off(idx_d)};
            dat_d = f_data(idx_d, mac_d, ip_d, gw_d, port_d, en_d);
            sel_d = f_sel(idx_d);
        end
        busy_d  = (state_d == S_REQ) || (state_d == S_GAP) || (state_d == S_FAIL);
        done_d  = (state_d == S_DONE);
        error_d = error_q;
        code_d  = code_q;
        eidx_d  = eidx_q;
        if (state_q == S_IDLE && start) begin
            error_d = 1'b0;
            code_d  = ERR_NONE;
            eidx_d  = 3'd0;
        end else if (state_q == S_REQ && state_d == S_FAIL) begin
            error_d = 1'b1;
            code_d  = fail_code;
            eidx_d  = idx_q;
        end
    end

    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = cyc_q;
    assign wb_we_o   = we_q;
    assign wb_adr_o  = adr_q;
    assign wb_dat_o  = dat_q;
    assign wb_sel_o  = sel_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign err_code  = code_q;
    assign err_index = eidx_q;

endmodule
`default_nettype wire
